mult35x35_seq_pipe: RTL and testbench



---
 rtl/mult35_pkg.sv | 41 ++++
 rtl/mult18x18s_acc.sv | 45 ++++
 rtl/mult35x35_seq_pipe.sv | 163 ++++++++++++++++
 tb/tb_mult35x35_seq_pipe.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mult35_pkg.sv
// Shared definitions for the 35x35 sequential multiplier.
// Contents:
//   A_W, B_W, P_W, ACC_W, SPLIT, HALF_W : datapath widths
//   phase_t    : 2-bit free-running phase of the 4-clock schedule
//   acc_op_t   : addend select for the 18x18 multiply/accumulate slice
//   next_phase : phase sequencing helper (0,1,2,3,0,...)
package mult35_pkg;

    localparam int A_W    = 35;
    localparam int B_W    = 35;
    localparam int P_W    = A_W + B_W;
    localparam int ACC_W  = 48;
    localparam int SPLIT  = 17;
    localparam int HALF_W = SPLIT + 1;

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        ADD_ZERO  = 2'd0,
        ADD_P     = 2'd1,
        ADD_P_SHR = 2'd2
    } acc_op_t;

    function automatic phase_t next_phase(input phase_t ph);
        phase_t nxt;
        case (ph)
            PH0:     nxt = PH1;
            PH1:     nxt = PH2;
            PH2:     nxt = PH3;
            PH3:     nxt = PH0;
            default: nxt = PH0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mult18x18s_acc.sv
// Registered 18x18 signed multiply with accumulate of a selectable addend.
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset, clears the accumulator
//   a, b   : signed 18-bit multiplier inputs
//   op_sel : addend select (zero, accumulator, accumulator >>> SPLIT)
//   acc    : registered signed 48-bit accumulator
module mult18x18s_acc
    import mult35_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [HALF_W-1:0] a,
    input  logic signed [HALF_W-1:0] b,
    input  acc_op_t                 op_sel,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*HALF_W-1:0] prod_s;
    logic signed [ACC_W-1:0]    addend_s;

    // Both operands are sign-extended first, so the truncated product is exact.
    assign prod_s = (2*HALF_W)'(a) * (2*HALF_W)'(b);

    // Addend mux; the shifted form carries the upper partial sum to the next column.
    always_comb begin
        addend_s = 48'sd0;
        case (op_sel)
            ADD_ZERO:  addend_s = 48'sd0;
            ADD_P:     addend_s = acc;
            ADD_P_SHR: addend_s = acc >>> SPLIT;
            default:   addend_s = 48'sd0;
        endcase
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= 48'sd0;
        end else begin
            acc <= addend_s + ACC_W'(prod_s);
        end
    end

endmodule

// File: rtl/mult35x35_seq_pipe.sv
// Signed 35x35 -> 70-bit multiplier built on one time-shared 18x18 MAC slice.
// Operands are sampled at every phase-0 edge; each product appears on
// PROD_OUT five clocks after its capture edge, one product per four clocks.
// Ports:
//   CLK      : rising-edge clock
//   RST      : synchronous active-high reset
//   A_IN     : signed multiplicand (35 bits)
//   B_IN     : signed multiplier (35 bits)
//   PROD_OUT : registered signed product (70 bits), held between updates
//   PROD_VLD : one-clock pulse in the cycle after each PROD_OUT update
//              (present only when MULT35_VALID_EN is defined)
module mult35x35_seq_pipe
    import mult35_pkg::*;
(
    input  logic           CLK,
    input  logic           RST,
    input  logic [A_W-1:0] A_IN,
    input  logic [B_W-1:0] B_IN,
    output logic [P_W-1:0] PROD_OUT
`ifdef MULT35_VALID_EN
    ,
    output logic           PROD_VLD
`endif
);

    phase_t                    ph_r;
    phase_t                    ph_nxt_s;
    acc_op_t                   op_s;
    logic [A_W-1:0]            a_r;
    logic [B_W-1:0]            b_r;
    logic signed [HALF_W-1:0]  al_s, ah_s, bl_s, bh_s;
    logic signed [HALF_W-1:0]  mul_a_s, mul_b_s;
    logic signed [ACC_W-1:0]   acc_s;
    logic [11:0]               acc_hi_unused_s;
    logic [SPLIT-1:0]          lo17_r;
    logic [SPLIT-1:0]          mid17_r;
    logic                      cap_vld_r;
    logic                      emit_r;
    logic [P_W-1:0]            prod_r;

    // Low halves are zero-extended magnitudes, high halves carry the sign.
    assign al_s = {1'b0, a_r[SPLIT-1:0]};
    assign ah_s = a_r[A_W-1:SPLIT];
    assign bl_s = {1'b0, b_r[SPLIT-1:0]};
    assign bh_s = b_r[B_W-1:SPLIT];

    // Only the low 36 accumulator bits form the product's top field.
    assign acc_hi_unused_s = acc_s[ACC_W-1:36];

    // Phase register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ph_r <= PH0;
        end else begin
            ph_r <= ph_nxt_s;
        end
    end

    // Next phase and slice operation for the edge that ends the current phase.
    always_comb begin
        ph_nxt_s = next_phase(ph_r);
        op_s     = ADD_ZERO;
        mul_a_s  = 18'sd0;
        mul_b_s  = 18'sd0;
        case (ph_r)
            PH1: begin
                op_s    = ADD_ZERO;
                mul_a_s = al_s;
                mul_b_s = bl_s;
            end
            PH2: begin
                op_s    = ADD_P_SHR;
                mul_a_s = ah_s;
                mul_b_s = bl_s;
            end
            PH3: begin
                op_s    = ADD_P;
                mul_a_s = al_s;
                mul_b_s = bh_s;
            end
            PH0: begin
                // Final column of the product in flight; the operand registers
                // still hold its values at this edge even though they reload now.
                op_s    = ADD_P_SHR;
                mul_a_s = ah_s;
                mul_b_s = bh_s;
            end
            default: begin
                op_s    = ADD_ZERO;
                mul_a_s = 18'sd0;
                mul_b_s = 18'sd0;
            end
        endcase
    end

    mult18x18s_acc u_mac (
        .clk    (CLK),
        .rst    (RST),
        .a      (mul_a_s),
        .b      (mul_b_s),
        .op_sel (op_s),
        .acc    (acc_s)
    );

    // Operand capture and pipeline bookkeeping at phase-0 edges.
    // emit_r marks that the window now finishing belongs to a real capture,
    // so nothing is emitted for the empty window right after reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_r       <= 35'd0;
            b_r       <= 35'd0;
            cap_vld_r <= 1'b0;
            emit_r    <= 1'b0;
        end else if (ph_r == PH0) begin
            a_r       <= A_IN;
            b_r       <= B_IN;
            cap_vld_r <= 1'b1;
            emit_r    <= cap_vld_r;
        end
    end

    // Low and middle 17-bit product fields, latched the edge after they settle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            lo17_r  <= 17'd0;
            mid17_r <= 17'd0;
        end else begin
            if (ph_r == PH2) begin
                lo17_r <= acc_s[SPLIT-1:0];
            end
            if (ph_r == PH0) begin
                mid17_r <= acc_s[SPLIT-1:0];
            end
        end
    end

    // Product output register, updated five clocks after capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            prod_r <= 70'd0;
        end else if ((ph_r == PH1) && emit_r) begin
            prod_r <= {acc_s[35:0], mid17_r, lo17_r};
        end
    end

    assign PROD_OUT = prod_r;

`ifdef MULT35_VALID_EN
    logic vld_r;

    // Valid pulse one clock after each product update.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_r <= 1'b0;
        end else begin
            vld_r <= (ph_r == PH2) && emit_r;
        end
    end

    assign PROD_VLD = vld_r;
`endif

endmodule

// File: tb/tb_mult35x35_seq_pipe.sv
// Self-checking bench for mult35x35_seq_pipe. A behavioural model predicts
// PROD_OUT (and PROD_VLD when MULT35_VALID_EN is defined) every clock from
// the edge count since reset release and plain 70-bit signed arithmetic.
module tb_mult35x35_seq_pipe;

    logic        CLK;
    logic        RST;
    logic [34:0] A_IN;
    logic [34:0] B_IN;
    logic [69:0] PROD_OUT;
`ifdef MULT35_VALID_EN
    logic        PROD_VLD;
`endif

    mult35x35_seq_pipe dut (
        .CLK      (CLK),
        .RST      (RST),
        .A_IN     (A_IN),
        .B_IN     (B_IN),
        .PROD_OUT (PROD_OUT)
`ifdef MULT35_VALID_EN
        ,
        .PROD_VLD (PROD_VLD)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int          due;
        logic [69:0] val;
    } pend_t;

    int          n_total = 0;
    int          n_bad   = 0;
    int          edge_n  = 0;
    logic [69:0] exp_prod = 70'd0;
    logic        exp_vld  = 1'b0;
    logic        upd_now  = 1'b0;
    pend_t       pend[$];
    logic [69:0] seen[$];
    logic        rec_on = 1'b0;

    task automatic chk_eq(input string tag, input logic [69:0] got, input logic [69:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [69:0] ref_mul(input logic [34:0] a, input logic [34:0] b);
        logic signed [69:0] sa;
        logic signed [69:0] sb;
        sa = {{35{a[34]}}, a};
        sb = {{35{b[34]}}, b};
        return sa * sb;
    endfunction

    // Reference: capture every 4th edge after reset release, result 5 edges later.
    task automatic model_edge(input logic r, input logic [34:0] a, input logic [34:0] b);
        pend_t p;
        if (r) begin
            edge_n   = 0;
            exp_prod = 70'd0;
            exp_vld  = 1'b0;
            upd_now  = 1'b0;
            pend.delete();
        end else begin
            exp_vld = upd_now;
            upd_now = 1'b0;
            if (pend.size() > 0 && pend[0].due == edge_n) begin
                exp_prod = pend[0].val;
                void'(pend.pop_front());
                upd_now = 1'b1;
            end
            if (edge_n % 4 == 0) begin
                p.due = edge_n + 5;
                p.val = ref_mul(a, b);
                pend.push_back(p);
            end
            edge_n++;
        end
    endtask

    task automatic step(input logic r, input logic [34:0] a, input logic [34:0] b);
        @(negedge CLK);
        RST  = r;
        A_IN = a;
        B_IN = b;
        @(posedge CLK);
        model_edge(r, a, b);
        #1;
        chk_eq("prod", PROD_OUT, exp_prod);
`ifdef MULT35_VALID_EN
        chk_eq("vld", {69'd0, PROD_VLD}, {69'd0, exp_vld});
`endif
        if (rec_on && upd_now) seen.push_back(PROD_OUT);
    endtask

    // Reset, hold one operand pair through capture and latency, then check the literal result.
    task automatic direct(input string tag, input logic [34:0] a, input logic [34:0] b,
                          input logic [69:0] want);
        step(1'b1, 35'd0, 35'd0);
        step(1'b1, 35'd0, 35'd0);
        for (int i = 0; i < 5; i++) step(1'b0, a, b);
        chk_eq({tag, "_pre"}, PROD_OUT, 70'd0);
        step(1'b0, a, b);
        chk_eq(tag, PROD_OUT, want);
    endtask

    function automatic logic [34:0] rand35();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[34:0];
    endfunction

    initial begin
        logic [34:0] xa;
        logic [34:0] ya;
        logic [69:0] uniq[$];
        logic [69:0] stream_exp[4];
        logic [34:0] stream_op[4];

        RST  = 1'b1;
        A_IN = 35'd0;
        B_IN = 35'd0;

        step(1'b1, 35'd0, 35'd0);
        chk_eq("reset", PROD_OUT, 70'd0);

        direct("sq512", 35'd512, 35'd512, 70'h40000);

        // Stream, each value held 7 clocks.
        stream_op[0] = 35'd2020;     stream_exp[0] = 70'h3E4310;
        stream_op[1] = 35'd10;       stream_exp[1] = 70'h64;
        stream_op[2] = 35'd1115;     stream_exp[2] = 70'h12F859;
        stream_op[3] = 35'hF00000;   stream_exp[3] = 70'hE10000000000;
        step(1'b1, 35'd0, 35'd0);
        step(1'b1, 35'd0, 35'd0);
        seen.delete();
        rec_on = 1'b1;
        for (int v = 0; v < 4; v++)
            for (int i = 0; i < 7; i++) step(1'b0, stream_op[v], stream_op[v]);
        for (int i = 0; i < 8; i++) step(1'b0, stream_op[3], stream_op[3]);
        rec_on = 1'b0;
        foreach (seen[i])
            if (uniq.size() == 0 || uniq[uniq.size()-1] != seen[i]) uniq.push_back(seen[i]);
        chk_eq("stream_n", 70'(uniq.size()), 70'd4);
        for (int i = 0; i < 4 && i < uniq.size(); i++) chk_eq("stream_val", uniq[i], stream_exp[i]);

        direct("neg1x1",  35'h7_FFFF_FFFF, 35'd1,          70'h3F_FFFF_FFFF_FFFF_FFFF);
        direct("minxmin", 35'h4_0000_0000, 35'h4_0000_0000, 70'h10_0000_0000_0000_0000);
        direct("maxxnmax",35'h3_FFFF_FFFF, 35'h4_0000_0001, 70'h30_0000_0007_FFFF_FFFF);
        direct("maxsq",   35'h3_FFFF_FFFF, 35'h3_FFFF_FFFF, 70'h0F_FFFF_FFF8_0000_0001);
        direct("zero_a",  35'd0,           rand35(),        70'd0);
        direct("zero_b",  rand35(),        35'd0,           70'd0);

        // Operands toggle every clock; only phase-0 values may matter.
        step(1'b1, 35'd0, 35'd0);
        for (int i = 0; i < 200; i++) step(1'b0, rand35(), rand35());

        // Reset in the middle of a computation.
        xa = 35'h1_2345_6789;
        ya = 35'h6_5432_1001;
        step(1'b1, 35'd0, 35'd0);
        for (int i = 0; i < 7; i++) step(1'b0, xa, xa);
        chk_eq("pre_rst", PROD_OUT, ref_mul(xa, xa));
        step(1'b1, xa, xa);
        chk_eq("rst_mid", PROD_OUT, 70'd0);
        for (int i = 0; i < 5; i++) step(1'b0, ya, xa);
        chk_eq("no_stale", PROD_OUT, 70'd0);
        step(1'b0, ya, xa);
        chk_eq("after_rst", PROD_OUT, ref_mul(ya, xa));

        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++)
            step(($urandom_range(99, 0) < 3) ? 1'b1 : 1'b0, rand35(), rand35());

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
